// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared result/status outputs and the
// shared-ALU drive/return signals used by alu_arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic                     req0;
    logic                     req1;
    logic [3:0]               ctl0;
    logic [3:0]               ctl1;
    logic signed [DATA_W-1:0] a0;
    logic signed [DATA_W-1:0] b0;
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] b1;
    logic                     gnt0;
    logic                     gnt1;
    logic                     done0;
    logic                     done1;
    logic signed [DATA_W-1:0] result;
    logic                     zero;
    logic                     err;
    logic                     busy;
    logic [3:0]               alu_control;
    logic signed [DATA_W-1:0] alu_a;
    logic signed [DATA_W-1:0] alu_b;
    logic signed [DATA_W-1:0] alu_result;
    logic                     alu_zero;

    // Requesters and the external ALU sit on the master side.
    modport master (
        output req0, req1, ctl0, ctl1, a0, b0, a1, b1, alu_result, alu_zero,
        input  gnt0, gnt1, done0, done1, result, zero, err, busy,
               alu_control, alu_a, alu_b
    );

    modport slave (
        input  req0, req1, ctl0, ctl1, a0, b0, a1, b1, alu_result, alu_zero,
        output gnt0, gnt1, done0, done1, result, zero, err, busy,
               alu_control, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE/EXEC/RESP).
// Define ALU_ARB_RR_EN for round-robin on simultaneous requests; default is fixed priority to requester 0.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]               state;
    logic [3:0]               op_ctl_p0;
    logic signed [DATA_W-1:0] op_a_p0;
    logic signed [DATA_W-1:0] op_b_p0;
    logic                     winner_p0;
    logic                     gnt0_p0;
    logic                     gnt1_p0;
    logic                     done0_p1;
    logic                     done1_p1;
    logic signed [DATA_W-1:0] result_p1;
    logic                     zero_p1;
    logic                     err_p1;
    logic                     any_req;
    logic                     pick1;

    function automatic logic ctl_invalid(input logic [3:0] ctl);
        return ctl > 4'd10;
    endfunction

    assign any_req = bus.req0 | bus.req1;

`ifdef ALU_ARB_RR_EN
    logic last_gnt;

    // last_gnt holds the ID granted most recently; on a tie the other side wins.
    assign pick1 = bus.req1 & (~bus.req0 | ~last_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_gnt <= pick1;
        end
    end
`else
    assign pick1 = bus.req1 & ~bus.req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_ctl_p0 <= '0;
            op_a_p0   <= '0;
            op_b_p0   <= '0;
            winner_p0 <= 1'b0;
            gnt0_p0   <= 1'b0;
            gnt1_p0   <= 1'b0;
            done0_p1  <= 1'b0;
            done1_p1  <= 1'b0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            gnt0_p0  <= 1'b0;
            gnt1_p0  <= 1'b0;
            done0_p1 <= 1'b0;
            done1_p1 <= 1'b0;
            case (state)
                // IDLE -> EXEC: capture the winner's operation
                IDLE: begin
                    if (any_req) begin
                        state     <= EXEC;
                        winner_p0 <= pick1;
                        op_ctl_p0 <= pick1 ? bus.ctl1 : bus.ctl0;
                        op_a_p0   <= pick1 ? bus.a1 : bus.a0;
                        op_b_p0   <= pick1 ? bus.b1 : bus.b0;
                        gnt0_p0   <= ~pick1;
                        gnt1_p0   <= pick1;
                    end
                end
                // EXEC -> RESP: capture the shared ALU outputs
                EXEC: begin
                    state     <= RESP;
                    result_p1 <= bus.alu_result;
                    zero_p1   <= bus.alu_zero;
                    err_p1    <= ctl_invalid(op_ctl_p0);
                    done0_p1  <= ~winner_p0;
                    done1_p1  <= winner_p0;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0        = gnt0_p0;
    assign bus.gnt1        = gnt1_p0;
    assign bus.done0       = done0_p1;
    assign bus.done1       = done1_p1;
    assign bus.result      = result_p1;
    assign bus.zero        = zero_p1;
    assign bus.err         = err_p1;
    assign bus.busy        = (state != IDLE);
    assign bus.alu_control = op_ctl_p0;
    assign bus.alu_a       = op_a_p0;
    assign bus.alu_b       = op_b_p0;
endmodule
